// File: rtl/task_ack_arbiter_pkg.sv
// Shared definitions for the toggle-handshake task arbiter: FSM state
// encoding and width helpers used by the interface and the top level.
package task_ack_pkg;

  // Arbiter FSM: waiting for a request, issuing a task, waiting for the worker.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } arbStateT;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    for (int b = 0; b < 32; b++) begin
      if (remaining > 0) begin
        result++;
        remaining = remaining >> 1;
      end
    end
    return result;
  endfunction

  // Channel id width, never narrower than one bit so a single channel still works.
  function automatic int idWidth(input int channels);
    return (clog2(channels) < 1) ? 1 : clog2(channels);
  endfunction

endpackage

// File: rtl/task_ack_arbiter_if.sv
// Bundle of the requester-facing toggle handshake and the worker-facing task
// port. The master side is the environment (requesters plus worker); the
// slave side is the arbiter itself.
interface task_ack_arbiter_if #(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 32
);
  import task_ack_pkg::*;

  localparam int ID_W = idWidth(CHANNELS);

  logic [CHANNELS-1:0]        req_toggle_async;
  logic [CHANNELS*DATA_W-1:0] req_data_async;
  logic [CHANNELS-1:0]        ack_toggle;
  logic [CHANNELS-1:0]        ack_status;
  logic                       task_start;
  logic [ID_W-1:0]            task_id;
  logic [DATA_W-1:0]          task_data;
  logic                       task_busy;
  logic                       task_done;
  logic                       task_abort;

  modport master (
    output req_toggle_async,
    output req_data_async,
    output task_done,
    input  ack_toggle,
    input  ack_status,
    input  task_start,
    input  task_id,
    input  task_data,
    input  task_busy,
    input  task_abort
  );

  modport slave (
    input  req_toggle_async,
    input  req_data_async,
    input  task_done,
    output ack_toggle,
    output ack_status,
    output task_start,
    output task_id,
    output task_data,
    output task_busy,
    output task_abort
  );

endinterface

// File: rtl/task_ack_arbiter_toggle_sync.sv
// Multi-bit flop-chain synchroniser for level/toggle signals arriving from
// foreign clock domains. Each bit is synchronised independently, which is
// safe because every bit is a toggle that changes at most once per handshake.
module toggle_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] asyncIn,
  output logic [WIDTH-1:0] syncOut
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] syncChain;

  // Shift the asynchronous inputs through the chain; stage 0 is the metastable capture flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncChain <= '0;
    end else begin
      syncChain[0] <= asyncIn;
      for (int s = 1; s < STAGES; s++) begin
        syncChain[s] <= syncChain[s-1];
      end
    end
  end

  assign syncOut = syncChain[STAGES-1];

endmodule

// File: rtl/task_ack_arbiter.sv
// Receiving side of the toggle-based task handshake. Requesters in other
// clock domains flip a request toggle; this block synchronises the toggles,
// picks one pending channel round-robin, hands its payload to a local worker
// and flips the channel's ack toggle when the worker finishes or the
// watchdog gives up on it.
module task_ack_arbiter
  import task_ack_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT     = 0
) (
  input logic             clk,
  input logic             rst,
  task_ack_arbiter_if.slave bus
);

  localparam int ID_W  = idWidth(CHANNELS);
  localparam int CNT_W = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;

  arbStateT            state;
  arbStateT            nextState;
  logic [CHANNELS-1:0] reqSync;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] ackToggleQ;
  logic [CHANNELS-1:0] ackStatusQ;
  logic [ID_W-1:0]     lastGrant;
  logic [ID_W-1:0]     grantId;
  logic [ID_W-1:0]     candidate;
  logic                grantValid;
  logic [DATA_W-1:0]   grantData;
  logic [ID_W-1:0]     taskIdQ;
  logic [DATA_W-1:0]   taskDataQ;
  logic [CNT_W-1:0]    watchdogCnt;
  logic                timeoutHit;
  logic                taskAbortQ;
  logic                finishDone;
  logic                finishAbort;

  toggle_sync #(
    .WIDTH  (CHANNELS),
    .STAGES (SYNC_STAGES)
  ) reqSyncInst (
    .clk     (clk),
    .rst     (rst),
    .asyncIn (bus.req_toggle_async),
    .syncOut (reqSync)
  );

  // A channel owes us work whenever its synchronised request differs from our ack.
  assign pending = reqSync ^ ackToggleQ;

  // Round-robin search: first pending channel strictly after the last grant, wrapping around.
  always_comb begin
    grantValid = 1'b0;
    grantId    = '0;
    candidate  = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      candidate = ID_W'((int'(lastGrant) + i) % CHANNELS);
      if (!grantValid && pending[candidate]) begin
        grantValid = 1'b1;
        grantId    = candidate;
      end
    end
  end

  // Select the winning channel's payload; the requester keeps it stable until it sees the ack.
  always_comb begin
    grantData = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (grantId == ID_W'(c)) begin
        grantData = bus.req_data_async[c*DATA_W +: DATA_W];
      end
    end
  end

  // Watchdog fires on the last allowed busy cycle; a zero limit disables it entirely.
  assign timeoutHit = (TIMEOUT != 0) && (watchdogCnt == CNT_W'(TIMEOUT - 1));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and finish decode; worker completion takes precedence over the watchdog.
  always_comb begin
    nextState   = state;
    finishDone  = 1'b0;
    finishAbort = 1'b0;
    case (state)
      IDLE: begin
        if (grantValid) begin
          nextState = START;
        end
      end
      START, RUN: begin
        if (bus.task_done) begin
          finishDone = 1'b1;
          nextState  = IDLE;
        end else if (timeoutHit) begin
          finishAbort = 1'b1;
          nextState   = IDLE;
        end else begin
          nextState = RUN;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Task capture, watchdog counting, abort pulse and per-channel ack/status bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taskIdQ     <= '0;
      taskDataQ   <= '0;
      lastGrant   <= ID_W'(CHANNELS - 1);
      watchdogCnt <= '0;
      taskAbortQ  <= 1'b0;
      ackToggleQ  <= '0;
      ackStatusQ  <= '0;
    end else begin
      taskAbortQ <= finishAbort;
      if (state == IDLE && grantValid) begin
        taskIdQ     <= grantId;
        taskDataQ   <= grantData;
        lastGrant   <= grantId;
        watchdogCnt <= '0;
      end else if (state != IDLE) begin
        watchdogCnt <= watchdogCnt + CNT_W'(1);
      end
      for (int c = 0; c < CHANNELS; c++) begin
        if ((finishDone || finishAbort) && taskIdQ == ID_W'(c)) begin
          ackToggleQ[c] <= ~ackToggleQ[c];
          ackStatusQ[c] <= finishAbort;
        end
      end
    end
  end

  assign bus.task_start = (state == START);
  assign bus.task_busy  = (state != IDLE);
  assign bus.task_id    = taskIdQ;
  assign bus.task_data  = taskDataQ;
  assign bus.task_abort = taskAbortQ;
  assign bus.ack_toggle = ackToggleQ;
  assign bus.ack_status = ackStatusQ;

endmodule

// File: tb/tb_task_ack_arbiter.sv
// Directed bench for task_ack_arbiter: reset values, stray done, single
// request latency, round-robin order, watchdog abort, done/timeout race and
// reset in the middle of a task.
module tb_task_ack_arbiter;
  import task_ack_pkg::*;

  localparam int CHANNELS    = 4;
  localparam int DATA_W      = 32;
  localparam int SYNC_STAGES = 3;
  localparam int TIMEOUT     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  task_ack_arbiter_if #(.CHANNELS(CHANNELS), .DATA_W(DATA_W)) bus();

  task_ack_arbiter #(
    .CHANNELS    (CHANNELS),
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Absolute bound on the run in case the design stops responding.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [CHANNELS-1:0] flipMask);
    bus.req_toggle_async = bus.req_toggle_async ^ flipMask;
  endtask

  task automatic waitForStart(input string tag, input int expId, input logic [31:0] expData);
    int n;
    n = 0;
    while (bus.task_start !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checkOutput({tag, "_start"}, 64'(bus.task_start), 64'd1);
    checkOutput({tag, "_id"}, 64'(bus.task_id), 64'(expId));
    checkOutput({tag, "_data"}, 64'(bus.task_data), 64'(expData));
  endtask

  task automatic finishNow();
    bus.task_done = 1'b1;
    tick();
    bus.task_done = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    int busyCycles;
    int starts;
    bus.req_toggle_async = '0;
    bus.req_data_async   = {32'hC0DE_0003, 32'hA5A5_0002, 32'hC0DE_0001, 32'hC0DE_0000};
    bus.task_done        = 1'b0;

    repeat (3) tick();
    checkOutput("rst_ack", 64'(bus.ack_toggle), 64'h0);
    checkOutput("rst_status", 64'(bus.ack_status), 64'h0);
    checkOutput("rst_start", 64'(bus.task_start), 64'h0);
    checkOutput("rst_busy", 64'(bus.task_busy), 64'h0);
    checkOutput("rst_abort", 64'(bus.task_abort), 64'h0);
    checkOutput("rst_id", 64'(bus.task_id), 64'h0);
    checkOutput("rst_data", 64'(bus.task_data), 64'h0);
    rst = 1'b0;

    $display("[TB] stray done in idle");
    bus.task_done = 1'b1;
    tick();
    bus.task_done = 1'b0;
    tick();
    checkOutput("stray_ack", 64'(bus.ack_toggle), 64'h0);
    checkOutput("stray_busy", 64'(bus.task_busy), 64'h0);
    checkOutput("stray_start", 64'(bus.task_start), 64'h0);

    $display("[TB] single request on channel 2");
    applyStimulus(4'b0100);
    repeat (3) tick();
    checkOutput("single_early", 64'(bus.task_start), 64'h0);
    tick();
    checkOutput("single_start", 64'(bus.task_start), 64'h1);
    checkOutput("single_id", 64'(bus.task_id), 64'h2);
    checkOutput("single_data", 64'(bus.task_data), 64'hA5A5_0002);
    tick();
    checkOutput("single_run_start", 64'(bus.task_start), 64'h0);
    checkOutput("single_run_busy", 64'(bus.task_busy), 64'h1);
    repeat (4) tick();
    checkOutput("single_ack_wait", 64'(bus.ack_toggle), 64'h0);
    finishNow();
    checkOutput("single_ack", 64'(bus.ack_toggle), 64'b0100);
    checkOutput("single_status", 64'(bus.ack_status), 64'h0);
    checkOutput("single_busy_end", 64'(bus.task_busy), 64'h0);

    $display("[TB] fairness after reset");
    rst = 1'b1;
    tick();
    checkOutput("rst2_ack", 64'(bus.ack_toggle), 64'h0);
    bus.req_toggle_async = '0;
    tick();
    rst = 1'b0;
    applyStimulus(4'b1011);
    waitForStart("fair0", 0, 32'hC0DE_0000);
    finishNow();
    checkOutput("fair0_ack", 64'(bus.ack_toggle), 64'b0001);
    checkOutput("fair0_idle", 64'(bus.task_busy), 64'h0);
    waitForStart("fair1", 1, 32'hC0DE_0001);
    finishNow();
    checkOutput("fair1_ack", 64'(bus.ack_toggle), 64'b0011);
    waitForStart("fair3", 3, 32'hC0DE_0003);
    finishNow();
    checkOutput("fair3_ack", 64'(bus.ack_toggle), 64'b1011);
    applyStimulus(4'b0001);
    waitForStart("solo0", 0, 32'hC0DE_0000);
    finishNow();
    checkOutput("solo0_ack", 64'(bus.ack_toggle), 64'b1010);
    applyStimulus(4'b1001);
    waitForStart("rr3", 3, 32'hC0DE_0003);
    finishNow();
    checkOutput("rr3_ack", 64'(bus.ack_toggle), 64'b0010);
    waitForStart("rr0", 0, 32'hC0DE_0000);
    finishNow();
    checkOutput("rr0_ack", 64'(bus.ack_toggle), 64'b0011);

    $display("[TB] watchdog abort on channel 1");
    applyStimulus(4'b0010);
    waitForStart("wd", 1, 32'hC0DE_0001);
    busyCycles = 0;
    while (bus.task_busy === 1'b1 && busyCycles < 20) begin
      busyCycles++;
      tick();
    end
    checkOutput("wd_busy_len", 64'(busyCycles), 64'd8);
    checkOutput("wd_ack", 64'(bus.ack_toggle), 64'b0001);
    checkOutput("wd_status", 64'(bus.ack_status), 64'b0010);
    checkOutput("wd_abort", 64'(bus.task_abort), 64'h1);
    tick();
    checkOutput("wd_abort_once", 64'(bus.task_abort), 64'h0);
    applyStimulus(4'b0010);
    waitForStart("wd_next", 1, 32'hC0DE_0001);
    finishNow();
    checkOutput("wd_next_ack", 64'(bus.ack_toggle), 64'b0011);
    checkOutput("wd_next_status", 64'(bus.ack_status), 64'h0);

    $display("[TB] done and timeout in the same cycle");
    applyStimulus(4'b0100);
    waitForStart("race", 2, 32'hA5A5_0002);
    repeat (7) tick();
    checkOutput("race_busy", 64'(bus.task_busy), 64'h1);
    finishNow();
    checkOutput("race_busy_end", 64'(bus.task_busy), 64'h0);
    checkOutput("race_ack", 64'(bus.ack_toggle), 64'b0111);
    checkOutput("race_status", 64'(bus.ack_status), 64'h0);
    checkOutput("race_abort", 64'(bus.task_abort), 64'h0);
    tick();
    checkOutput("race_abort_late", 64'(bus.task_abort), 64'h0);

    $display("[TB] reset during a running task");
    applyStimulus(4'b0001);
    waitForStart("mid", 0, 32'hC0DE_0000);
    tick();
    tick();
    checkOutput("mid_running", 64'(bus.task_busy), 64'h1);
    rst = 1'b1;
    #1;
    checkOutput("mid_ack", 64'(bus.ack_toggle), 64'h0);
    checkOutput("mid_status", 64'(bus.ack_status), 64'h0);
    checkOutput("mid_start", 64'(bus.task_start), 64'h0);
    checkOutput("mid_busy", 64'(bus.task_busy), 64'h0);
    checkOutput("mid_abort", 64'(bus.task_abort), 64'h0);
    checkOutput("mid_id", 64'(bus.task_id), 64'h0);
    checkOutput("mid_data", 64'(bus.task_data), 64'h0);
    bus.req_toggle_async = '0;
    tick();
    tick();
    rst = 1'b0;
    starts = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.task_start === 1'b1 || bus.task_abort === 1'b1) starts++;
    end
    checkOutput("post_rst_quiet", 64'(starts), 64'd0);
    checkOutput("post_rst_ack", 64'(bus.ack_toggle), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/task_ack_arbiter.md
# task_ack_arbiter

Multi-channel, single-clock receiving side of the toggle-based task handshake. Up to CHANNELS remote requesters, each in its own clock domain, signal a task by flipping a request toggle and holding a payload. This block synchronises the toggles, round-robin arbitrates among pending channels, and hands one task at a time to a local worker. It returns per-channel acknowledge toggles with a completion status and supports an optional watchdog timeout that aborts stuck tasks.

## Interface
- CHANNELS, 4: number of requester channels (1..16).
- DATA_W, 32: payload width per channel.
- SYNC_STAGES, 3: synchroniser depth for request toggles (≥2).
- TIMEOUT, 0: max cycles a task may run before abort; 0 disables the watchdog.
- ID_W, derived: clog2(CHANNELS), minimum 1.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- req_toggle_async  in  CHANNELS  per-channel request toggle from foreign domains.
- req_data_async  in  CHANNELS*DATA_W  channel i payload at bits [i*DATA_W +: DATA_W]. Stable from before its toggle flips until its ack is seen.
- ack_toggle  out  CHANNELS  flips once per completed or aborted task of channel i.
- ack_status  out  CHANNELS  status of channel i's last task (0 = done, 1 = timed out). Updated on the same edge as ack_toggle[i].
- task_start  out  1  one-cycle pulse; task_id and task_data valid.
- task_id  out  ID_W  granted channel, held while task_busy.
- task_data  out  DATA_W  captured payload, held while task_busy.
- task_busy  out  1  high from the task_start cycle until completion or abort.
- task_done  in  1  worker completion; sampled only while task_busy.
- task_abort  out  1  one-cycle pulse after a watchdog abort.

## Operation
- Each req_toggle_async bit passes through a SYNC_STAGES flop chain; req_sync is the last stage.
- Channel i is pending when req_sync[i] differs from ack_toggle[i].
- FSM has three states: IDLE, START, RUN.
- IDLE: if any channel is pending, grant the first pending channel searching from last_grant+1 modulo CHANNELS.
  - On the grant: latch task_id and the channel's task_data from req_data_async, set last_grant, go to START.
  - If nothing is pending, stay in IDLE.
- START: task_start = 1 for this cycle, watchdog counter cleared.
  - If task_done = 1: complete. Otherwise go to RUN.
- RUN: wait for task_done.
  - Counter increments each cycle in START/RUN.
  - When TIMEOUT ≠ 0 and the counter reaches TIMEOUT−1 with task_done = 0: abort.
- Complete: ack_toggle[id] flips, ack_status[id] ← 0, state → IDLE.
- Abort: ack_toggle[id] flips, ack_status[id] ← 1, task_abort ← 1 for the next cycle, state → IDLE. The worker must discard the task.
- task_done and timeout in the same cycle: done wins, status 0.
- task_done outside task_busy is ignored.
- A requester toggling again before it has observed its ack violates the protocol. Both flips merge into a single task; no detection is performed.
- Reset clears all state and outputs, including synchronisers and ack_toggle. Remote requesters must reset together with this block.
- Reset asserted mid-task drops the task silently: no ack and no abort pulse.

## Timing
- Reset values: ack_toggle = 0, ack_status = 0, task_start = 0, task_busy = 0, task_abort = 0, task_id = 0, task_data = 0, state IDLE, last_grant = CHANNELS−1 (channel 0 has first priority).
- Request toggle flips before edge 0 → req_sync changes at edge SYNC_STAGES−1 → grant at edge SYNC_STAGES → task_start high during the following cycle.
- ack_toggle flips on the edge that samples task_done = 1. Fastest turnaround: done in the START cycle gives the ack at edge SYNC_STAGES+1.
- After completion the block spends ≥1 cycle in IDLE, so back-to-back tasks are separated by at least one idle cycle.
- Watchdog: with TIMEOUT = T, task_busy lasts exactly T cycles on abort.
- All outputs are registered, except task_start and task_busy, which decode the state register directly.

## Structure
- Package task_ack_pkg holds the FSM state encoding constants (IDLE/START/RUN) and a clog2 function for ID_W.
- Sub-module toggle_sync: a parametrised (WIDTH, STAGES) flop-chain synchroniser with async reset. It carries the per-bit CDC constraint attributes.
- Round-robin priority search, payload mux, watchdog counter and FSM stay in the top level.

## Test plan
- Single request: CHANNELS = 4, SYNC_STAGES = 3, data[2] = 0xA5A5_0002, flip toggle[2] → task_start at cycle 4 with task_id = 2 and task_data = 0xA5A5_0002. Raise task_done 5 cycles later → ack_toggle[2] = 1, ack_status[2] = 0.
- Fairness: flip channels 0, 1 and 3 simultaneously, completing each task in 1 cycle → grant order 0, 1, 3. Re-request 0 and 3 together → order 3, 0.
- Timeout: TIMEOUT = 8, task on channel 1, no done → task_busy high for 8 cycles, then ack_toggle[1] flips, ack_status[1] = 1, task_abort pulses once. A later normal task on channel 1 returns status 0.
- Simultaneous done and timeout: task_done asserted in cycle TIMEOUT−1 → status 0, no task_abort.
- Reset mid-task: assert rst during RUN → all outputs 0 immediately. After release with requester toggles also 0, no task_start occurs.
- Stray done: task_done pulsed in IDLE → no ack change, no state change.
